// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM read-side (and future write-side) helpers.
package sram_pkg;

  localparam int unsigned RAM_ADDR_W = 4;
  localparam int unsigned RAM_DATA_W = 8;
  localparam int unsigned RAM_DEPTH  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StFlush,
    StDone
  } rb_state_e;

endpackage

// File: rtl/rb_skid_fifo.sv
// Two-entry synchronous FIFO with push/pop/count; head is always visible on head.
module rb_skid_fifo
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W = RAM_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push && !pop) begin
        count_q <= count_q + 2'd1;
      end else if (pop && !push) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // A push into a full FIFO without a simultaneous pop means the issuer broke its credit rule.
  overflow_a : assert property (@(posedge CLK) disable iff (!RESET_N)
    !(push && !pop && count_q == 2'd2))
    else $error("rb_skid_fifo: overflow");

  underflow_a : assert property (@(posedge CLK) disable iff (!RESET_N)
    !(pop && count_q == 2'd0))
    else $error("rb_skid_fifo: underflow");

endmodule

// File: rtl/sram_readback.sv
// Walks a RAM address range through the synchronous read port and streams words out.
// Optional trailing XOR checksum word when SRAM_READBACK_CKSUM_EN is defined.
module sram_readback
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W    = RAM_ADDR_W,
  parameter int unsigned DATA_W    = RAM_DATA_W,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              ram_cs,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  rb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              inflight_q;

  logic [DATA_W-1:0] fifo_head;
  logic [1:0]        fifo_count;
  logic              fifo_pop;
  logic              drained;
  logic [2:0]        occ;
  logic              issue;
  logic              tail_accept;

  rb_skid_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .push     (inflight_q),
    .push_data(ram_rdata),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  assign fifo_pop = (fifo_count != 2'd0) && out_ready;
  assign drained  = (fifo_count == 2'd0) && !inflight_q;

  // Stored words plus the one in flight, less the one leaving now, must leave room for another.
  assign occ   = 3'(fifo_count) + 3'(inflight_q) - 3'(fifo_pop);
  assign issue = (state_q == StRead) && (remaining_q != '0) && (occ < 3'(BUF_DEPTH));

  assign ram_cs   = issue;
  assign ram_rd   = issue;
  assign ram_addr = issue ? cur_addr_q : '0;

`ifdef SRAM_READBACK_CKSUM_EN
  logic [DATA_W-1:0] cksum_q;
  logic              cksum_phase;

  assign cksum_phase = (state_q == StFlush) && drained;
  assign out_valid   = (fifo_count != 2'd0) || cksum_phase;
  assign out_data    = cksum_phase ? cksum_q : fifo_head;
  assign tail_accept = cksum_phase && out_ready;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cksum_q <= '0;
    end else if (state_q == StIdle && start) begin
      cksum_q <= '0;
    end else if (fifo_pop) begin
      cksum_q <= cksum_q ^ fifo_head;
    end
  end
`else
  assign out_valid   = (fifo_count != 2'd0);
  assign out_data    = fifo_head;
  assign tail_accept = drained;
`endif

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    busy        = (state_q != StIdle);
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_addr_d  = start_addr;
          remaining_d = len;
          state_d     = (len != '0) ? StRead : StFlush;
        end
      end
      StRead: begin
        if (issue) begin
          cur_addr_d  = cur_addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (ADDR_W+1)'(1)) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (tail_accept) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= issue;
    end
  end

endmodule

// File: tb/tb_sram_readback.sv
// Randomized self-checking bench for sram_readback against a queue-based transfer model.
// Honours SRAM_READBACK_CKSUM_EN for the trailing checksum word.
module tb_sram_readback;

`ifdef SRAM_READBACK_CKSUM_EN
  localparam bit CksumEn = 1'b1;
`else
  localparam bit CksumEn = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] len;
  logic       ram_cs, ram_rd;
  logic [3:0] ram_addr;
  logic [7:0] ram_rdata = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy, done;

  logic [7:0] mem [16];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  sram_readback dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .start     (start),
    .start_addr(start_addr),
    .len       (len),
    .ram_cs    (ram_cs),
    .ram_rd    (ram_rd),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // Behavioural RAM: one-cycle synchronous read, untouched by reset.
  always @(posedge CLK) begin
    if (ram_cs && ram_rd) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_cs"}, 32'(ram_cs), 0);
    chk({tag, "_ram_rd"}, 32'(ram_rd), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  function automatic logic pick_ready(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2 == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // mode: 0 ready high, 1 ready toggles, 2 random ready. abort_after>0: reset after that many words.
  task automatic xfer(input int sa, input int ln, input int mode, input bit poke,
                      input int abort_after, input bit lat_chk);
    logic [7:0] exp_d[$];
    logic [3:0] exp_a[$];
    logic [7:0] x = 8'h00;
    int strobes = 0, acc = 0, first_v = -1, first_s = -1, done_k = -1, last_acc_k = -1;
    bit hold = 1'b0, aborted = 1'b0;
    logic [7:0] hold_d = 8'h00;
    for (int i = 0; i < ln; i++) begin
      exp_a.push_back(4'((sa + i) % 16));
      exp_d.push_back(mem[(sa + i) % 16]);
      x ^= mem[(sa + i) % 16];
    end
    if (CksumEn) exp_d.push_back(x);

    @(posedge CLK); #1;
    start = 1'b1; start_addr = 4'(sa); len = 5'(ln); out_ready = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int k = 0; k < 300 && done_k < 0 && !aborted; k++) begin
      if (k > 0) begin
        @(posedge CLK); #1;
        start = 1'b0;
      end
      out_ready = pick_ready(mode, k);
      if (poke && k == 3) begin
        start = 1'b1; start_addr = 4'($urandom); len = 5'($urandom_range(1, 16));
      end
      #3;
      if (ram_cs) begin
        chk("ram_rd_eq_cs", 32'(ram_rd), 1);
        chk("strobe_expected", 32'(exp_a.size() != 0), 1);
        if (exp_a.size() != 0) chk("ram_addr", 32'(ram_addr), 32'(exp_a.pop_front()));
        strobes++;
        if (first_s < 0) first_s = k;
      end else begin
        chk("ram_addr_idle", 32'(ram_addr), 0);
      end
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(hold_d));
      end
      hold   = out_valid && !out_ready;
      hold_d = out_data;
      if (out_valid && first_v < 0) first_v = k;
      if (out_valid && out_ready) begin
        chk("word_expected", 32'(exp_d.size() != 0), 1);
        if (exp_d.size() != 0) chk("out_data", 32'(out_data), 32'(exp_d.pop_front()));
        if (mode == 0 && last_acc_k >= 0) chk("back_to_back", k, last_acc_k + 1);
        last_acc_k = k;
        acc++;
      end
      chk("occupancy_le_2", 32'(strobes - acc <= 2), 1);
      if (done) begin
        chk("busy_with_done", 32'(busy), 1);
        done_k = k;
      end
      if (abort_after > 0 && acc == abort_after) begin
        RESET_N = 1'b0;
        #1;
        chk_all_zero("abort");
        aborted = 1'b1;
      end
    end

    if (aborted) begin
      @(posedge CLK); #1;
      chk_all_zero("in_reset");
      RESET_N = 1'b1;
      out_ready = 1'b1;
    end else begin
      chk("done_seen", 32'(done_k >= 0), 1);
      chk("data_left", exp_d.size(), 0);
      chk("addr_left", exp_a.size(), 0);
      if (lat_chk) begin
        chk("first_strobe_cycle", first_s, 0);
        chk("first_valid_cycle", first_v, 2);
      end
`ifndef SRAM_READBACK_CKSUM_EN
      if (ln == 0) begin
        chk("len0_done_cycle", done_k, 1);
        chk("len0_no_valid", first_v, -1);
      end
`endif
      for (int j = 0; j < 2; j++) begin
        @(posedge CLK); #4;
        chk("post_done", 32'(done), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_cs", 32'(ram_cs), 0);
        chk("post_valid", 32'(out_valid), 0);
      end
    end
  endtask

  initial begin
    RESET_N = 1'b0; start = 1'b0; start_addr = '0; len = '0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
    #7;
    chk_all_zero("reset");
    @(posedge CLK); #1;
    RESET_N = 1'b1;

    xfer(3, 4, 0, 1'b0, 0, 1'b1);
    xfer(14, 4, 0, 1'b0, 0, 1'b0);
    xfer(5, 16, 1, 1'b0, 0, 1'b0);
    xfer(2, 8, 0, 1'b0, 3, 1'b0);
    xfer(2, 8, 0, 1'b0, 0, 1'b1);
    xfer(7, 6, 2, 1'b1, 0, 1'b0);
    xfer(9, 0, 0, 1'b0, 0, 1'b0);

`ifdef SRAM_READBACK_CKSUM_EN
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
    xfer(0, 4, 0, 1'b0, 0, 1'b0);
    xfer(0, 0, 0, 1'b0, 0, 1'b0);
`endif

    for (int t = 0; t < 12; t++) begin
      int ln;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      ln = $urandom_range(0, 16);
      xfer($urandom_range(0, 15), ln, $urandom_range(0, 2), (ln >= 5) && 1'($urandom), 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
